spi_reg_bank: RTL and testbench

- SPI slave that writes the 32×16 control register array consumed by the register decoder.
- Sits between the front-end MCU's SPI master and the decoder.
- Supports write frames that update one register and read frames that return one register on MISO for host verification.
- All SPI pins are oversampled in the system clock domain; no logic runs on the SPI clock.

---
 rtl/spi_reg_pkg.sv | 22 ++
 rtl/spi_sync_edge.sv | 41 ++++
 rtl/spi_reg_bank.sv | 153 +++++++++++++++
 tb/tb_spi_reg_bank.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register bank.
// Holds the frame geometry, the frame FSM state encoding and the register
// indices that the downstream decoder uses.
package spi_reg_pkg;

    localparam int FRAME_BITS = 24;
    localparam int CMD_BITS   = 8;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        DATA,
        COMMIT,
        WAIT_CS
    } state_t;

    // Register indices consumed by the decoder
    localparam int REG_CH1_GEAR  = 2;
    localparam int REG_TIME_GEAR = 7;
    localparam int REG_OBJECT    = 14;

endpackage

// File: rtl/spi_sync_edge.sv
// Synchroniser plus edge strobes for one asynchronous SPI pin.
//   clk, rst_n : system clock, synchronous active-low reset
//   din        : raw asynchronous input
//   dout       : synchronised level
//   rise, fall : one-clk strobes on synchronised edges
// Edge strobes are held off until the chain has refilled with real samples
// after reset, so a pin that was already low at reset release (e.g. cs_n held
// through a reset) never produces a phantom edge.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [SYNC_STAGES:0]   warm_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
            warm_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
            warm_q <= {warm_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];
    assign rise = warm_q[SYNC_STAGES] &  dout & ~prev_q;
    assign fall = warm_q[SYNC_STAGES] & ~dout &  prev_q;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 slave writing a bank of control registers.
//   clk, rst_n         : system clock, synchronous active-low reset
//   spi_sclk/cs_n/mosi : raw SPI pins, oversampled in the clk domain
//   spi_miso           : read data, MSB first, 0 when not shifting read data
//   regs               : register array consumed by the decoder
//   wr_pulse, wr_addr  : one-clk strobe and index of a committed write
//   frame_err          : one-clk strobe when cs_n rises before 24 bits
// Frame: {rw, addr[6:0]} then data[15:0], MSB first.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int NUM_REGS    = 32,
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2,
    localparam int AW         = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [DATA_W-1:0] regs [NUM_REGS],
    output logic              wr_pulse,
    output logic [AW-1:0]     wr_addr,
    output logic              frame_err
);

    localparam logic [4:0] CMD_LAST   = 5'(CMD_BITS - 1);
    localparam logic [4:0] FRAME_LAST = 5'(FRAME_BITS - 1);
    localparam logic [6:0] ADDR_LIM   = 7'(NUM_REGS);

    logic sclk_rise, sclk_fall, sclk_lvl;
    logic cs_s, cs_fall, cs_rise;
    logic mosi_s, mosi_rise, mosi_fall;
    logic unused_edges;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst_n(rst_n), .din(spi_sclk),
        .dout(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(clk), .rst_n(rst_n), .din(spi_cs_n),
        .dout(cs_s), .rise(cs_rise), .fall(cs_fall));

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(clk), .rst_n(rst_n), .din(spi_mosi),
        .dout(mosi_s), .rise(mosi_rise), .fall(mosi_fall));

    assign unused_edges = ^{sclk_lvl, cs_rise, mosi_rise, mosi_fall};

    state_t              state_q, state_nx;
    logic [4:0]          bit_cnt_q;
    logic [CMD_BITS-2:0] cmd_sh_q;
    logic                rw_q;
    logic [6:0]          addr_q;
    logic [DATA_W-1:0]   wr_sh_q, rd_sh_q;

    logic [CMD_BITS-1:0] cmd_word;
    logic                last_rise;
    logic                abort;
    logic                do_write;

    assign cmd_word  = {cmd_sh_q, mosi_s};
    assign last_rise = sclk_rise && (bit_cnt_q == FRAME_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_nx;
    end

    // Next state; the 24th rising edge wins over a simultaneous cs_n release
    always_comb begin
        state_nx = state_q;
        case (state_q)
            IDLE:    if (cs_fall) state_nx = CMD;
            CMD: begin
                if (cs_s)                                       state_nx = IDLE;
                else if (sclk_rise && (bit_cnt_q == CMD_LAST))  state_nx = DATA;
            end
            DATA: begin
                if (last_rise) state_nx = COMMIT;
                else if (cs_s) state_nx = IDLE;
            end
            COMMIT:  state_nx = WAIT_CS;
            WAIT_CS: if (cs_s) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        abort    = ((state_q == CMD) || (state_q == DATA)) && (state_nx == IDLE);
        do_write = (state_q == COMMIT) && !rw_q && (addr_q < ADDR_LIM);
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            spi_miso  <= 1'b0;
            wr_pulse  <= 1'b0;
            wr_addr   <= '0;
            frame_err <= 1'b0;
            bit_cnt_q <= '0;
            cmd_sh_q  <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wr_sh_q   <= '0;
            rd_sh_q   <= '0;
        end else begin
            wr_pulse  <= 1'b0;
            frame_err <= abort;
            case (state_q)
                IDLE: bit_cnt_q <= '0;
                CMD: if (sclk_rise) begin
                    cmd_sh_q  <= cmd_word[CMD_BITS-2:0];
                    bit_cnt_q <= bit_cnt_q + 5'd1;
                    if (bit_cnt_q == CMD_LAST) begin
                        rw_q    <= cmd_word[7];
                        addr_q  <= cmd_word[6:0];
                        wr_sh_q <= '0;
                        // Out-of-range reads return zero
                        if (cmd_word[7] && (cmd_word[6:0] < ADDR_LIM))
                            rd_sh_q <= regs[cmd_word[AW-1:0]];
                        else
                            rd_sh_q <= '0;
                    end
                end
                DATA: begin
                    if (sclk_rise) begin
                        wr_sh_q   <= {wr_sh_q[DATA_W-2:0], mosi_s};
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                    end
                    // First fall in DATA is the 8th fall: it presents bit 15
                    if (sclk_fall && rw_q) begin
                        spi_miso <= rd_sh_q[DATA_W-1];
                        rd_sh_q  <= {rd_sh_q[DATA_W-2:0], 1'b0};
                    end
                end
                COMMIT: if (do_write) begin
                    regs[addr_q[AW-1:0]] <= wr_sh_q;
                    wr_pulse             <= 1'b1;
                    wr_addr              <= addr_q[AW-1:0];
                end
                default: ;
            endcase
            if (state_nx == IDLE) spi_miso <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
module tb_spi_reg_bank;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b0;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic [15:0] regs [32];
    logic        wr_pulse;
    logic [4:0]  wr_addr;
    logic        frame_err;

    spi_reg_bank #(.NUM_REGS(32), .DATA_W(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .spi_sclk(sclk), .spi_cs_n(cs_n),
        .spi_mosi(mosi), .spi_miso(miso), .regs(regs),
        .wr_pulse(wr_pulse), .wr_addr(wr_addr), .frame_err(frame_err));

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [15:0] data;
    } wr_t;

    int          total = 0;
    int          bad = 0;
    wr_t         wr_q[$];
    logic [15:0] rd_q[$];
    logic        err_q[$];
    logic [15:0] model [32];
    logic        rd_valid = 1'b0;
    logic [15:0] rd_word = '0;
    wr_t         wr_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 32; i++)
            check($sformatf("%s reg%0d", tag, i), 32'(regs[i]), 32'(model[i]));
    endtask

    task automatic push_wr(input logic [4:0] a, input logic [15:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        wr_q.push_back(e);
        model[a] = d;
    endtask

    // One SPI frame, sclk period 8 clk. rst_at >= 0 pulses rst_n before that bit.
    task automatic frame(input logic [7:0] cmd, input logic [15:0] data, input int nbits,
                         input int gap, input bit cs_with_last, input int rst_at);
        logic [23:0] bits;
        logic [15:0] got;
        bits = {cmd, data};
        got  = '0;
        cs_n = 1'b0;
        clks(4);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst_n = 1'b0;
                clks(2);
                rst_n = 1'b1;
                for (int k = 0; k < 32; k++) model[k] = '0;
            end
            mosi = bits[23-i];
            clks(4);
            if (i >= 8) got = {got[14:0], miso};
            sclk = 1'b1;
            if (cs_with_last && i == nbits - 1) cs_n = 1'b1;
            clks(4);
            sclk = 1'b0;
        end
        if (cmd[7] && nbits == 24) begin
            rd_word  = got;
            rd_valid = 1'b1;
            clks(1);
            rd_valid = 1'b0;
        end
        clks(4);
        cs_n = 1'b1;
        mosi = 1'b0;
        clks(gap);
    endtask

    // DUT-side monitor: commits and frame errors
    always @(negedge clk) begin
        if (wr_pulse) begin
            if (wr_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected wr_pulse: got addr %0h want none", wr_addr);
            end else begin
                wr_e = wr_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(wr_e.addr));
                check("wr_data", 32'(regs[wr_addr]), 32'(wr_e.data));
            end
        end
        if (frame_err) begin
            if (err_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected frame_err: got 1 want 0");
            end else begin
                check("frame_err", 32'(frame_err), 32'(err_q.pop_front()));
            end
        end
    end

    // Read-word monitor
    always @(posedge clk) begin
        if (rd_valid) begin
            if (rd_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected read: got %0h want none", rd_word);
            end else begin
                check("miso_word", 32'(rd_word), 32'(rd_q.pop_front()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 32; k++) model[k] = '0;
        clks(3);
        check("reset miso", 32'(miso), 32'd0);
        check("reset wr_pulse", 32'(wr_pulse), 32'd0);
        check("reset wr_addr", 32'(wr_addr), 32'd0);
        check("reset frame_err", 32'(frame_err), 32'd0);
        check_regs("reset");
        rst_n = 1'b1;
        clks(10);

        // Simple write
        push_wr(5'd2, 16'h0005);
        frame(8'h02, 16'h0005, 24, 10, 0, -1);
        check_regs("w02");

        // Write then read back
        push_wr(5'd14, 16'hBEEF);
        frame(8'h0E, 16'hBEEF, 24, 10, 0, -1);
        rd_q.push_back(16'hBEEF);
        frame(8'h8E, 16'h0000, 24, 10, 0, -1);
        check_regs("r8E");

        // Aborted frame, then a good one
        err_q.push_back(1'b1);
        frame(8'h07, 16'h0003, 12, 10, 0, -1);
        check_regs("abort07");
        push_wr(5'd7, 16'h0003);
        frame(8'h07, 16'h0003, 24, 10, 0, -1);
        check_regs("w07");

        // Out-of-range write and read
        frame(8'h45, 16'hFFFF, 24, 10, 0, -1);
        check_regs("w45");
        rd_q.push_back(16'h0000);
        frame(8'hC5, 16'h0000, 24, 10, 0, -1);

        // cs_n released together with the 24th edge
        push_wr(5'd3, 16'hA5A5);
        frame(8'h03, 16'hA5A5, 24, 10, 1, -1);
        check_regs("w03late");

        // Reset in the data phase
        push_wr(5'd20, 16'h1234);
        frame(8'h14, 16'h1234, 24, 10, 0, -1);
        check_regs("w14");
        frame(8'h14, 16'h9999, 24, 10, 0, 14);
        check_regs("rst14");
        check("post-rst wr_addr", 32'(wr_addr), 32'd0);
        push_wr(5'd20, 16'h5678);
        frame(8'h14, 16'h5678, 24, 10, 0, -1);
        check_regs("w14b");

        // Back-to-back frames, cs_n high for 3 clk
        push_wr(5'd16, 16'h1111);
        frame(8'h10, 16'h1111, 24, 3, 0, -1);
        push_wr(5'd17, 16'h2222);
        frame(8'h11, 16'h2222, 24, 10, 0, -1);
        check_regs("b2b");

        for (int t = 0; t < 200 && (wr_q.size() + rd_q.size() + err_q.size()) > 0; t++)
            clks(1);
        check("pending writes", 32'(wr_q.size()), 32'd0);
        check("pending reads", 32'(rd_q.size()), 32'd0);
        check("pending errors", 32'(err_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
